// File: rtl/uart_reporte_tiempo.sv
// uart_reporte_tiempo: on a start_in rising edge, latches a 7-digit BCD time and
// sends "T=MM:SS.mmm\r\n" over UART 8N1, reporting busy/done to the controller.
module uart_reporte_tiempo #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        reset_global,
    input  logic        start_in,
    input  logic [27:0] tiempo_bcd_in,
    output logic        tx_out,
    output logic        busy_out,
    output logic        done_out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [3:0]       r_byte;
    logic [27:0]      r_tiempo;
    logic             r_start_prev, r_done;
    logic             w_trig, w_tick, w_last;
    logic [7:0]       w_char;

    // Non-decimal nibbles are flagged as '?' instead of producing odd ASCII.
    function automatic logic [7:0] digit(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    assign w_trig   = start_in & ~r_start_prev;
    assign w_tick   = r_cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign w_last   = r_byte == 4'd12;
    assign busy_out = r_state != S_IDLE;
    assign done_out = r_done;

    always_comb begin
        w_char = 8'h0A;
        case (r_byte)
            4'd0:    w_char = 8'h54;
            4'd1:    w_char = 8'h3D;
            4'd2:    w_char = digit(r_tiempo[27:24]);
            4'd3:    w_char = digit(r_tiempo[23:20]);
            4'd4:    w_char = 8'h3A;
            4'd5:    w_char = digit(r_tiempo[19:16]);
            4'd6:    w_char = digit(r_tiempo[15:12]);
            4'd7:    w_char = 8'h2E;
            4'd8:    w_char = digit(r_tiempo[11:8]);
            4'd9:    w_char = digit(r_tiempo[7:4]);
            4'd10:   w_char = digit(r_tiempo[3:0]);
            4'd11:   w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    // Edge register resets high so a request already asserted at release is ignored.
    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_byte       <= '0;
            r_tiempo     <= '0;
            r_start_prev <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_start_prev <= start_in;
            r_state      <= w_next;
            r_done       <= (r_state == S_STOP) && w_tick && w_last;
            r_cnt        <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            if (r_state == S_DATA && w_tick)
                r_bit <= r_bit + 1'b1;
            if (r_state == S_IDLE && w_trig) begin
                r_tiempo <= tiempo_bcd_in;
                r_byte   <= '0;
            end else if (r_state == S_STOP && w_tick && !w_last) begin
                r_byte <= r_byte + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        tx_out = 1'b1;
        case (r_state)
            S_IDLE:  w_next = w_trig ? S_START : S_IDLE;
            S_START: begin
                tx_out = 1'b0;
                w_next = w_tick ? S_DATA : S_START;
            end
            S_DATA:  begin
                tx_out = w_char[r_bit];
                w_next = (w_tick && r_bit == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP:  w_next = w_tick ? (w_last ? S_IDLE : S_START) : S_STOP;
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_reporte_tiempo.sv
// tb_uart_reporte_tiempo: directed checks of the time-report UART using a
// bench-side 8N1 decoder; runs at 16 clocks per bit to keep reports short.
module tb_uart_reporte_tiempo;
    localparam int CPB     = 16;
    localparam int FRAME   = 13 * 10 * CPB;
    localparam int STOP_AT = CPB / 2 + 9 * CPB;
    localparam logic [103:0] L1 = 104'h543D30313A32332E3435360D0A;
    localparam logic [103:0] L3 = 104'h543D31323A33342E3536370D0A;
    localparam logic [103:0] L4 = 104'h543D30303A35392E39393F0D0A;
    localparam logic [103:0] L6 = 104'h543D35393A35392E3939390D0A;

    logic        clk = 1'b0;
    logic        reset_global = 1'b0;
    logic        start_in = 1'b0;
    logic [27:0] tiempo_bcd_in = '0;
    logic        tx_out, busy_out, done_out;

    int n_checks = 0;
    int n_fail = 0;
    int busy_total = 0;
    int done_total = 0;
    int rx_n = 0;
    int rx_cnt = 0;
    bit rx_busy = 1'b0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_bytes [0:127];

    always #5 clk = ~clk;

    uart_reporte_tiempo #(.CLK_FREQ(1_900_000), .BAUD(115200)) dut (
        .clk(clk), .reset_global(reset_global), .start_in(start_in),
        .tiempo_bcd_in(tiempo_bcd_in), .tx_out(tx_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    // Activity counters and a mid-bit sampling 8N1 receiver.
    always @(negedge clk) begin
        if (busy_out) busy_total <= busy_total + 1;
        if (done_out) done_total <= done_total + 1;
        if (!reset_global) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (!tx_out) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt + 1 == STOP_AT) begin
                if (tx_out && rx_n < 128) begin
                    rx_bytes[rx_n] <= rx_sh;
                    rx_n <= rx_n + 1;
                end
                rx_busy <= 1'b0;
            end else if (rx_cnt + 1 >= CPB / 2 + CPB && (rx_cnt + 1 - CPB / 2) % CPB == 0) begin
                rx_sh <= {tx_out, rx_sh[7:1]};
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [103:0] line(input int base);
        logic [103:0] v = '0;
        for (int i = 0; i < 13; i++) v = {v[95:0], rx_bytes[(base + i) % 128]};
        return v;
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_out !== 1'b1 && n < 3 * FRAME) begin
            step;
            n++;
        end
        if (done_out !== 1'b1) check_bit({tag, "_timeout"}, done_out, 1'b1);
    endtask

    task automatic run_len(output int n);
        logic v;
        v = tx_out;
        n = 0;
        while (tx_out === v && n < 1000) begin
            n++;
            step;
        end
    endtask

    initial begin
        int b_busy, b_done, b_rx, n;
        int runs [8] = '{48, 16, 16, 16, 16, 16, 16, 16};

        repeat (3) step;
        check_bit("rst_tx", tx_out, 1'b1);
        check_bit("rst_busy", busy_out, 1'b0);
        check_bit("rst_done", done_out, 1'b0);
        reset_global = 1'b1;
        repeat (2) step;

        // Basic report and bit timing of byte 0 ('T' = 0x54).
        tiempo_bcd_in = 28'h0123456;
        b_busy = busy_total; b_done = done_total; b_rx = rx_n;
        start_in = 1'b1;
        check_bit("t2_pre_trig_tx", tx_out, 1'b1);
        step;
        check_bit("t2_first_low", tx_out, 1'b0);
        check_bit("t2_busy_rise", busy_out, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_len(n);
            check_int($sformatf("t2_run%0d", i), n, runs[i]);
        end
        start_in = 1'b0;
        wait_done("t1");
        check_bit("t1_busy_at_done", busy_out, 1'b0);
        step;
        check_bit("t1_done_width", done_out, 1'b0);
        check_int("t1_bytes", rx_n - b_rx, 13);
        check_line("t1_line", line(b_rx), L1);
        check_int("t1_busy_cycles", busy_total - b_busy, FRAME);
        check_int("t1_done_count", done_total - b_done, 1);

        // Held request, a second edge mid-report, and a late input change.
        tiempo_bcd_in = 28'h1234567;
        b_busy = busy_total; b_done = done_total; b_rx = rx_n;
        start_in = 1'b1;
        repeat (100) step;
        tiempo_bcd_in = 28'h9999999;
        repeat (900) step;
        start_in = 1'b0;
        step;
        start_in = 1'b1;
        wait_done("t3");
        repeat (200) step;
        check_bit("t3_idle_after", busy_out, 1'b0);
        check_int("t3_bytes", rx_n - b_rx, 13);
        check_line("t3_line", line(b_rx), L3);
        check_int("t3_busy_cycles", busy_total - b_busy, FRAME);
        check_int("t3_done_count", done_total - b_done, 1);
        start_in = 1'b0;
        step;

        // Invalid BCD digit becomes '?'.
        tiempo_bcd_in = 28'h005999A;
        b_rx = rx_n;
        start_in = 1'b1;
        step;
        start_in = 1'b0;
        wait_done("t4");
        step;
        check_int("t4_bytes", rx_n - b_rx, 13);
        check_line("t4_line", line(b_rx), L4);

        // Asynchronous reset in the middle of byte 6, then a clean report.
        tiempo_bcd_in = 28'h0123456;
        start_in = 1'b1;
        step;
        start_in = 1'b0;
        repeat (1039) step;
        check_bit("t5_busy_before", busy_out, 1'b1);
        reset_global = 1'b0;
        #1;
        check_bit("t5_rst_tx", tx_out, 1'b1);
        check_bit("t5_rst_busy", busy_out, 1'b0);
        check_bit("t5_rst_done", done_out, 1'b0);
        repeat (3) step;
        reset_global = 1'b1;
        repeat (2) step;
        b_busy = busy_total; b_rx = rx_n;
        start_in = 1'b1;
        step;
        start_in = 1'b0;
        wait_done("t5");
        step;
        check_int("t5_bytes", rx_n - b_rx, 13);
        check_line("t5_line", line(b_rx), L1);
        check_int("t5_busy_cycles", busy_total - b_busy, FRAME);

        // Request already high at reset release, then back-to-back reports.
        reset_global = 1'b0;
        start_in = 1'b1;
        repeat (2) step;
        reset_global = 1'b1;
        b_busy = busy_total;
        repeat (50) step;
        check_bit("t6_no_tx", tx_out, 1'b1);
        check_bit("t6_no_busy", busy_out, 1'b0);
        check_int("t6_no_busy_cycles", busy_total - b_busy, 0);
        start_in = 1'b0;
        step;
        tiempo_bcd_in = 28'h0123456;
        b_busy = busy_total; b_done = done_total; b_rx = rx_n;
        start_in = 1'b1;
        step;
        start_in = 1'b0;
        wait_done("t6a");
        check_bit("t6_busy_at_done", busy_out, 1'b0);
        start_in = 1'b1;
        tiempo_bcd_in = 28'h5959999;
        step;
        check_bit("t6_b2b_tx", tx_out, 1'b0);
        check_bit("t6_b2b_busy", busy_out, 1'b1);
        start_in = 1'b0;
        wait_done("t6b");
        step;
        check_int("t6_bytes", rx_n - b_rx, 26);
        check_line("t6_line_a", line(b_rx), L1);
        check_line("t6_line_b", line(b_rx + 13), L6);
        check_int("t6_busy_cycles", busy_total - b_busy, 2 * FRAME);
        check_int("t6_done_count", done_total - b_done, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_reporte_tiempo.md
Name: uart_reporte_tiempo

Overview:
- Downstream consumer of the race-control FSM's `start_uart_tx_out`.
- On a rising edge of that request, it latches the stopwatch's 7-digit BCD elapsed time.
- It transmits that time as a fixed 13-byte ASCII line over UART 8N1: "T=MM:SS.mmm\r\n".
- It reports busy/done status back to the control logic.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (217 with the defaults), clock cycles per UART bit; integer division, truncated.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_global  input  1  asynchronous, active-low reset.
- start_in  input  1  transmit request; a level that may stay high for many cycles; only its rising edge acts.
- tiempo_bcd_in  input  28  {M1,M0,S1,S0,m2,m1,m0}, 4 bits per digit, M1 in [27:24], m0 in [3:0].
- tx_out  output  1  UART serial line; idles high.
- busy_out  output  1  high while a report is latched or being sent.
- done_out  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (reset_global=0, asynchronous):
  - tx_out=1, busy_out=0, done_out=0.
  - Edge-detect register resets to 1, so a start_in already high at reset release does not trigger.
  - All counters reset to 0.
  - Reset mid-frame aborts at once; the line returns high with no partial stop bit.
- Edge detect: trigger = start_in & ~start_prev, with start_prev registered every cycle.
- Trigger while busy_out=1 is ignored; nothing is queued.
- Trigger in IDLE, cycle N:
  - tiempo_bcd_in is latched into a 28-bit register.
  - From cycle N+1: busy_out=1 and tx_out=0 (start bit of byte 0).
  - Input changes after cycle N have no effect on the current report.
- States:
  - IDLE: wait for trigger.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles.
  - STOP exits to START if byte_idx<12 (byte_idx++), else to IDLE.
- Back-to-back bytes: no idle gap between STOP and the next START.
- Byte sequence, byte_idx 0..12:
  - 0: 'T' (0x54)
  - 1: '=' (0x3D)
  - 2: M1
  - 3: M0
  - 4: ':' (0x3A)
  - 5: S1
  - 6: S0
  - 7: '.' (0x2E)
  - 8: m2
  - 9: m1
  - 10: m0
  - 11: CR (0x0D)
  - 12: LF (0x0A)
- Digit encoding: 0x30 + digit for values 0-9; a digit above 9 is sent as '?' (0x3F).
- Total report duration: 13 × 10 × CLKS_PER_BIT = 28210 cycles at the defaults.
  - busy_out is high for exactly that many cycles (N+1 .. N+28210).
- End of report:
  - On the cycle after the last STOP period ends: busy_out=0 and done_out=1 for exactly one cycle; state is IDLE.
  - A trigger on that same cycle is accepted (its tx_out=0 start bit follows next cycle).
- Bit-counter wrap: the counter counts 0..CLKS_PER_BIT-1 and advances the bit on its terminal value; no other wrap exists.

Test Plan:
1. Digits {0,1,2,3,4,5,6}, start_in pulse → UART decoder receives 54 3D 30 31 3A 32 33 2E 34 35 36 0D 0A; busy_out high for 28210 cycles; a single done_out pulse.
2. Bit timing: measure the start bit of byte 0 and the bit edges of 0x54 → each bit 217 cycles ±0; first tx_out=0 exactly one cycle after the start_in rising edge.
3. start_in held high through the whole report, plus an extra 0→1 pulse at cycle 5000 → exactly one report; tiempo_bcd_in changed at cycle 100 does not alter the bytes.
4. Digits {0,0,5,9,9,9,0xA} → byte 10 is 0x3F; all other digits encode normally (line "T=00:59.99?\r\n").
5. reset_global asserted during byte 6 → tx_out=1, busy_out=0 asynchronously. After release, a new trigger sends a complete 13-byte line from 'T'.
6. start_in already high while reset_global deasserts → no transmission. Next rising edge → normal report; a trigger on the done_out cycle → second report starts next cycle, with no gap.
